// File: rtl/spi_master.sv
// rtl/spi_master.sv - bus-mapped SPI mode-0 master shared by the SD card and RTC chip selects
`timescale 1ns/1ps
module spi_master #(
  parameter int unsigned FAST_DIV = 4,
  parameter int unsigned SLOW_DIV = 42
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       phi2,
  input  logic       cs_n,
  input  logic       write_enable,
  input  logic [1:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_sdcard_cs,
  output logic       spi_rtc_cs
);

  localparam logic [7:0] FAST_RL = 8'(FAST_DIV - 1);
  localparam logic [7:0] SLOW_RL = 8'(SLOW_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state_q;
  logic       phi2_q;
  logic [3:0] ctrl_q;
  logic [7:0] shift_q, rx_q, div_q, div_rl_q;
  logic [2:0] bit_q;
  logic       busy_q, ovr_q, done_q, sclk_q, mosi_q;

  logic       strobe, wr_stb, rd_stb;
  logic [7:0] div_rl_d;
  logic [3:0] ctrl_d;

  assign strobe   = phi2_q & ~phi2 & ~cs_n;
  assign wr_stb   = strobe & write_enable;
  assign rd_stb   = strobe & ~write_enable;
  assign div_rl_d = ctrl_q[2] ? SLOW_RL : FAST_RL;
  // SD select wins when both selects are written together
  assign ctrl_d   = {data_in[3], data_in[2], data_in[1] & ~data_in[0], data_in[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phi2_q <= 1'b0;
    else          phi2_q <= phi2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'h0;
      shift_q  <= 8'h00;
      rx_q     <= 8'h00;
      div_q    <= 8'h00;
      div_rl_q <= 8'h00;
      bit_q    <= 3'd0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
    end else begin
      if (wr_stb && address == 2'd2 && data_in[1]) ovr_q <= 1'b0;
      if (rd_stb && address == 2'd0) done_q <= 1'b0;
      if (wr_stb && busy_q && (address == 2'd0 || address == 2'd1)) ovr_q <= 1'b1;
      if (wr_stb && !busy_q && address == 2'd1) ctrl_q <= ctrl_d;

      case (state_q)
        IDLE: begin
          if (wr_stb && address == 2'd0) begin
            shift_q  <= data_in;
            bit_q    <= 3'd7;
            div_q    <= div_rl_d;
            div_rl_q <= div_rl_d;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            mosi_q   <= data_in[7];
            sclk_q   <= 1'b0;
            state_q  <= LOW;
          end
        end
        LOW: begin
          if (div_q == 8'h00) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[6:0], spi_miso};
            div_q   <= div_rl_q;
            state_q <= HIGH;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        HIGH: begin
          if (div_q == 8'h00) begin
            sclk_q <= 1'b0;
            div_q  <= div_rl_q;
            if (bit_q != 3'd0) begin
              shift_q <= {shift_q[6:0], 1'b0};
              mosi_q  <= shift_q[6];
              bit_q   <= bit_q - 3'd1;
              state_q <= LOW;
            end else begin
              mosi_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (!cs_n) begin
      case (address)
        2'd0:    data_out = rx_q;
        2'd1:    data_out = {4'h0, ctrl_q};
        2'd2:    data_out = {5'h00, done_q, ovr_q, busy_q};
        default: data_out = 8'h00;
      endcase
    end
  end

  assign spi_clk       = sclk_q;
  assign spi_mosi      = mosi_q;
  assign spi_sdcard_cs = ~ctrl_q[0];
  assign spi_rtc_cs    = ~ctrl_q[1];
  assign irq_n         = ~(done_q & ctrl_q[3]);

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master
`timescale 1ns/1ps
module tb_spi_master;
  logic       clk = 1'b0;
  logic       reset_n, phi2, cs_n, write_enable, spi_miso;
  logic [1:0] address;
  logic [7:0] data_in, data_out;
  logic       irq_n, spi_clk, spi_mosi, spi_sdcard_cs, spi_rtc_cs;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] rx;
  } exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #3 clk = ~clk;

  spi_master #(.FAST_DIV(4), .SLOW_DIV(42)) dut (
    .clk(clk), .reset_n(reset_n), .phi2(phi2), .cs_n(cs_n),
    .write_enable(write_enable), .address(address), .data_in(data_in),
    .data_out(data_out), .irq_n(irq_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_sdcard_cs(spi_sdcard_cs), .spi_rtc_cs(spi_rtc_cs)
  );

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); cs_n = 1'b0; write_enable = 1'b1; address = a; data_in = d; phi2 = 1'b1;
    @(negedge clk); phi2 = 1'b0;
    @(posedge clk);
    @(negedge clk); cs_n = 1'b1; write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk); cs_n = 1'b0; write_enable = 1'b0; address = a; phi2 = 1'b1;
    @(negedge clk); phi2 = 1'b0; #1 d = data_out;
    @(posedge clk);
    @(negedge clk); cs_n = 1'b1;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] m);
    exp_t e;
    e.mosi = tx; e.rx = m;
    exp_q.push_back(e);
    spi_miso = m[7];
    bus_write(2'd0, tx);
  endtask

  // Holds STATUS on the bus (no strobes) and acts as the SPI slave until busy drops.
  task automatic monitor_xfer(input logic [7:0] m, output logic [7:0] mo, output int busy_cyc,
                              output int period, output bit to);
    int idx, rises, cyc, first_rise, second_rise;
    logic prev;
    cs_n = 1'b0; write_enable = 1'b0; address = 2'd2;
    mo = 8'h00; busy_cyc = 0; idx = 0; rises = 0; cyc = 0; first_rise = -1; second_rise = -1;
    prev = 1'b0; to = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      #1;
      if (data_out[0]) busy_cyc++;
      if (spi_clk && !prev) begin
        mo = {mo[6:0], spi_mosi};
        rises++;
        if (rises == 1) first_rise = cyc;
        if (rises == 2) second_rise = cyc;
      end
      if (!spi_clk && prev) begin
        idx++;
        if (idx < 8) spi_miso = m[7-idx];
      end
      prev = spi_clk;
      if (!data_out[0]) begin to = 1'b0; break; end
      @(negedge clk); cyc++;
    end
    cs_n = 1'b1;
    period = second_rise - first_rise;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    total_cnt++; if ({spi_clk, spi_mosi, spi_sdcard_cs, spi_rtc_cs, irq_n} !== 5'b01111)
      $display("FAIL reset_pins got=%b want=01111", {spi_clk, spi_mosi, spi_sdcard_cs, spi_rtc_cs, irq_n}); else pass_cnt++;
    total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data_out_idle got=%h want=00", data_out); else pass_cnt++;
    @(negedge clk); reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      total_cnt++; if (rd !== 8'h00) $display("FAIL reset_read_%0d got=%h want=00", a, rd); else pass_cnt++;
    end
  endtask

  task automatic test_fast_transfer();
    logic [7:0] mo, rd; int bc, per; bit to; exp_t e;
    bus_write(2'd1, 8'h01);
    total_cnt++; if ({spi_sdcard_cs, spi_rtc_cs} !== 2'b01) $display("FAIL fast_cs got=%b want=01", {spi_sdcard_cs, spi_rtc_cs}); else pass_cnt++;
    start_xfer(8'hA5, 8'h3C);
    monitor_xfer(8'h3C, mo, bc, per, to);
    e = exp_q.pop_front();
    total_cnt++; if (to) $display("FAIL fast_timeout busy never fell"); else pass_cnt++;
    total_cnt++; if (mo !== e.mosi) $display("FAIL fast_mosi got=%h want=%h", mo, e.mosi); else pass_cnt++;
    total_cnt++; if (bc !== 64) $display("FAIL fast_busy_cycles got=%0d want=64", bc); else pass_cnt++;
    total_cnt++; if (per !== 8) $display("FAIL fast_sclk_period got=%0d want=8", per); else pass_cnt++;
    total_cnt++; if ({spi_clk, spi_mosi} !== 2'b01) $display("FAIL fast_idle_pins got=%b want=01", {spi_clk, spi_mosi}); else pass_cnt++;
    bus_read(2'd2, rd);
    total_cnt++; if (rd !== 8'h04) $display("FAIL fast_status got=%h want=04", rd); else pass_cnt++;
    bus_read(2'd0, rd);
    total_cnt++; if (rd !== e.rx) $display("FAIL fast_rx got=%h want=%h", rd, e.rx); else pass_cnt++;
  endtask

  task automatic test_slow_transfer();
    logic [7:0] mo, rd; int bc, per; bit to; exp_t e;
    bus_write(2'd1, 8'h07);
    bus_read(2'd1, rd);
    total_cnt++; if (rd !== 8'h05) $display("FAIL slow_ctrl_readback got=%h want=05", rd); else pass_cnt++;
    total_cnt++; if ({spi_sdcard_cs, spi_rtc_cs} !== 2'b01) $display("FAIL slow_cs got=%b want=01", {spi_sdcard_cs, spi_rtc_cs}); else pass_cnt++;
    start_xfer(8'hFF, 8'h81);
    monitor_xfer(8'h81, mo, bc, per, to);
    e = exp_q.pop_front();
    total_cnt++; if (to) $display("FAIL slow_timeout busy never fell"); else pass_cnt++;
    total_cnt++; if (mo !== e.mosi) $display("FAIL slow_mosi got=%h want=%h", mo, e.mosi); else pass_cnt++;
    total_cnt++; if (bc !== 672) $display("FAIL slow_busy_cycles got=%0d want=672", bc); else pass_cnt++;
    total_cnt++; if (per !== 84) $display("FAIL slow_sclk_period got=%0d want=84", per); else pass_cnt++;
    bus_read(2'd0, rd);
    total_cnt++; if (rd !== e.rx) $display("FAIL slow_rx got=%h want=%h", rd, e.rx); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [7:0] mo, rd; int bc, per; bit to; exp_t e;
    start_xfer(8'hC3, 8'h5A);
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h00);
    bus_read(2'd2, rd);
    total_cnt++; if (rd !== 8'h03) $display("FAIL ovr_status_busy got=%h want=03", rd); else pass_cnt++;
    total_cnt++; if (spi_sdcard_cs !== 1'b0) $display("FAIL ovr_ctrl_dropped sd_cs=%b want=0", spi_sdcard_cs); else pass_cnt++;
    monitor_xfer(8'h5A, mo, bc, per, to);
    e = exp_q.pop_front();
    total_cnt++; if (to) $display("FAIL ovr_timeout busy never fell"); else pass_cnt++;
    total_cnt++; if (mo !== e.mosi) $display("FAIL ovr_mosi got=%h want=%h", mo, e.mosi); else pass_cnt++;
    bus_read(2'd2, rd);
    total_cnt++; if (rd !== 8'h06) $display("FAIL ovr_status_done got=%h want=06", rd); else pass_cnt++;
    bus_read(2'd0, rd);
    total_cnt++; if (rd !== e.rx) $display("FAIL ovr_rx got=%h want=%h", rd, e.rx); else pass_cnt++;
    bus_write(2'd2, 8'h02);
    bus_read(2'd2, rd);
    total_cnt++; if (rd !== 8'h00) $display("FAIL ovr_clear got=%h want=00", rd); else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [7:0] mo, rd; int bc, per; bit to; exp_t e;
    bus_write(2'd1, 8'h09);
    total_cnt++; if (irq_n !== 1'b1) $display("FAIL irq_idle got=%b want=1", irq_n); else pass_cnt++;
    start_xfer(8'h3C, 8'hC3);
    monitor_xfer(8'hC3, mo, bc, per, to);
    e = exp_q.pop_front();
    total_cnt++; if (to) $display("FAIL irq_timeout busy never fell"); else pass_cnt++;
    total_cnt++; if (irq_n !== 1'b0) $display("FAIL irq_asserted got=%b want=0", irq_n); else pass_cnt++;
    bus_read(2'd0, rd);
    total_cnt++; if (rd !== e.rx) $display("FAIL irq_rx got=%h want=%h", rd, e.rx); else pass_cnt++;
    total_cnt++; if (irq_n !== 1'b1) $display("FAIL irq_cleared got=%b want=1", irq_n); else pass_cnt++;
  endtask

  task automatic test_rtc_select();
    logic [7:0] rd;
    bus_write(2'd1, 8'h02);
    bus_read(2'd1, rd);
    total_cnt++; if (rd !== 8'h02) $display("FAIL rtc_ctrl_readback got=%h want=02", rd); else pass_cnt++;
    total_cnt++; if ({spi_sdcard_cs, spi_rtc_cs} !== 2'b10) $display("FAIL rtc_cs got=%b want=10", {spi_sdcard_cs, spi_rtc_cs}); else pass_cnt++;
    bus_write(2'd3, 8'hFF);
    bus_read(2'd3, rd);
    total_cnt++; if (rd !== 8'h00) $display("FAIL reserved_read got=%h want=00", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] mo, rd; int rises, bc, per; bit to; logic prev; exp_t e;
    bus_write(2'd1, 8'h01);
    start_xfer(8'h81, 8'hFF);
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      @(negedge clk); #1;
      if (spi_clk && !prev) rises++;
      prev = spi_clk;
    end
    total_cnt++; if (rises !== 4) $display("FAIL midrst_reach_bit4 got=%0d want=4", rises); else pass_cnt++;
    void'(exp_q.pop_front());
    reset_n = 1'b0; #1;
    total_cnt++; if ({spi_clk, spi_mosi, spi_sdcard_cs, spi_rtc_cs, irq_n} !== 5'b01111)
      $display("FAIL midrst_pins got=%b want=01111", {spi_clk, spi_mosi, spi_sdcard_cs, spi_rtc_cs, irq_n}); else pass_cnt++;
    cs_n = 1'b0;
    for (int a = 0; a < 3; a++) begin
      address = 2'(a); #1;
      total_cnt++; if (data_out !== 8'h00) $display("FAIL midrst_read_%0d got=%h want=00", a, data_out); else pass_cnt++;
    end
    cs_n = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    bus_read(2'd2, rd);
    total_cnt++; if (rd !== 8'h00) $display("FAIL midrst_no_done got=%h want=00", rd); else pass_cnt++;
    bus_write(2'd1, 8'h01);
    start_xfer(8'h96, 8'h69);
    monitor_xfer(8'h69, mo, bc, per, to);
    e = exp_q.pop_front();
    total_cnt++; if (to) $display("FAIL midrst_timeout busy never fell"); else pass_cnt++;
    total_cnt++; if (mo !== e.mosi) $display("FAIL midrst_mosi got=%h want=%h", mo, e.mosi); else pass_cnt++;
    total_cnt++; if (bc !== 64) $display("FAIL midrst_busy_cycles got=%0d want=64", bc); else pass_cnt++;
    bus_read(2'd0, rd);
    total_cnt++; if (rd !== e.rx) $display("FAIL midrst_rx got=%h want=%h", rd, e.rx); else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0; phi2 = 1'b0; cs_n = 1'b1; write_enable = 1'b0;
    address = 2'd0; data_in = 8'h00; spi_miso = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_fast_transfer();
    test_slow_transfer();
    test_overrun();
    test_irq();
    test_rtc_select();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
